// File: rtl/wb_unit.sv
// wb_unit -- writeback arbiter and queue in front of the register bank write port.
//
// The unit merges results from two producers (LSU and ALU) into one circular FIFO.
// The head of the FIFO drives the register bank write port. It retires one entry
// per cycle, and the consumer is always ready.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 synchronous discard of every queued result
//   lsu_valid_i/ready_o     LSU producer handshake, with lsu_rd_i / lsu_data_i
//   alu_valid_i/ready_o     ALU producer handshake, with alu_rd_i / alu_data_i
//   we_o, waddr_o, wdata_o  register bank write port (address/data are 0 when idle)
//   busy_o                  per-register pending-write mask (bit 0 always 0)
//   count_o                 number of occupied queue entries
module wb_unit #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       lsu_valid_i,
  output logic                       lsu_ready_o,
  input  logic [$clog2(NUMREGS)-1:0] lsu_rd_i,
  input  logic [DATAWIDTH-1:0]       lsu_data_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [$clog2(NUMREGS)-1:0] alu_rd_i,
  input  logic [DATAWIDTH-1:0]       alu_data_i,
  output logic                       we_o,
  output logic [$clog2(NUMREGS)-1:0] waddr_o,
  output logic [DATAWIDTH-1:0]       wdata_o,
  output logic [NUMREGS-1:0]         busy_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int RW = $clog2(NUMREGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LIM_ONE = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LIM_TWO = CW'(DEPTH - 2);

  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [RW-1:0]        r_rd_mem   [DEPTH];
  logic [DATAWIDTH-1:0] r_data_mem [DEPTH];

  logic                 w_lsu_push;
  logic                 w_alu_push;
  logic                 w_pop;
  logic [PW-1:0]        w_alu_wptr;
  logic [PW-1:0]        w_wptr_next;
  logic [DEPTH-1:0]     w_entry_live;
  logic [NUMREGS-1:0]   w_busy;

  // Readiness depends only on the registered count. A same-cycle pop is
  // deliberately not credited, which keeps the ready path short.
  // When the LSU is also offering a result, the ALU needs room for two entries.
  assign lsu_ready_o = !flush_i && (r_count <= LIM_ONE);
  assign alu_ready_o = !flush_i && (lsu_valid_i ? (r_count <= LIM_TWO)
                                                : (r_count <= LIM_ONE));

  // A result for x0 still completes its handshake, but it never occupies a slot.
  assign w_lsu_push = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
  assign w_alu_push = alu_valid_i && alu_ready_o && (alu_rd_i != '0);

  // The LSU result is the older of the two, so it takes the first free slot.
  assign w_alu_wptr  = w_lsu_push ? (r_wptr + PW'(1)) : r_wptr;
  assign w_wptr_next = r_wptr + PW'(w_lsu_push) + PW'(w_alu_push);

  assign w_pop   = (r_count != '0) && !flush_i;
  assign we_o    = w_pop;
  assign waddr_o = w_pop ? r_rd_mem[r_rptr]   : '0;
  assign wdata_o = w_pop ? r_data_mem[r_rptr] : '0;
  assign count_o = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr <= w_wptr_next;
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= r_count + CW'(w_lsu_push) + CW'(w_alu_push) - CW'(w_pop);
    end
  end

  // Entry storage is not reset. Only entries inside the count window are ever
  // observed, so stale contents are harmless.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_lsu_push && (r_wptr == PW'(i))) begin
        r_rd_mem[i]   <= lsu_rd_i;
        r_data_mem[i] <= lsu_data_i;
      end else if (w_alu_push && (w_alu_wptr == PW'(i))) begin
        r_rd_mem[i]   <= alu_rd_i;
        r_data_mem[i] <= alu_data_i;
      end
    end
  end

  // An entry is live when its distance from the read pointer, taken modulo
  // DEPTH, is less than the occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_live
      logic [PW-1:0] w_off;
      assign w_off            = PW'(gi) - r_rptr;
      assign w_entry_live[gi] = ({1'b0, w_off} < r_count);
    end
  endgenerate

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_live[i]) begin
        w_busy[r_rd_mem[i]] = 1'b1;
      end
    end
    w_busy[0] = 1'b0;
  end

  assign busy_o = w_busy;

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] busy_o;
  logic [2:0]  count_o;

  wb_unit #(.NUMREGS(32), .DATAWIDTH(32), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        fl;
    logic        exp_lr;
    logic        exp_ar;
    int          exp_cnt;
  } vec_t;

  ent_t sb[$];
  vec_t tbl[19];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic fl);
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    flush_i = fl;
  endtask

  // Runs at the falling edge: compares the DUT against the scoreboard, then
  // advances the scoreboard to reflect what the next rising edge will do.
  task automatic model_step();
    int          m_cnt;
    logic        m_lr, m_ar, m_we;
    logic [31:0] m_busy;
    m_cnt = sb.size();
    m_lr  = !flush_i && (m_cnt <= 3);
    m_ar  = !flush_i && (lsu_valid_i ? (m_cnt <= 2) : (m_cnt <= 3));
    m_we  = (m_cnt != 0) && !flush_i;
    $display("[TB] lv=%0b lrd=%0d av=%0b ard=%0d fl=%0b -> we=%0b waddr=%0d wdata=%h cnt=%0d busy=%h",
             lsu_valid_i, lsu_rd_i, alu_valid_i, alu_rd_i, flush_i,
             we_o, waddr_o, wdata_o, count_o, busy_o);
    chk("lsu_ready", {63'd0, lsu_ready_o}, {63'd0, m_lr});
    chk("alu_ready", {63'd0, alu_ready_o}, {63'd0, m_ar});
    chk("we", {63'd0, we_o}, {63'd0, m_we});
    if (m_we) begin
      chk("waddr", 64'(waddr_o), 64'(sb[0].rd));
      chk("wdata", 64'(wdata_o), 64'(sb[0].data));
    end else begin
      chk("waddr_idle", 64'(waddr_o), 64'd0);
      chk("wdata_idle", 64'(wdata_o), 64'd0);
    end
    m_busy = '0;
    foreach (sb[k]) m_busy[sb[k].rd] = 1'b1;
    chk("busy", 64'(busy_o), 64'(m_busy));
    chk("count", 64'(count_o), 64'(m_cnt));
    chk("count_max", {63'd0, (count_o <= 3'd4)}, 64'd1);
    if (flush_i) begin
      sb.delete();
    end else begin
      if (m_we) void'(sb.pop_front());
      if (lsu_valid_i && m_lr && (lsu_rd_i != 5'd0)) sb.push_back({lsu_rd_i, lsu_data_i});
      if (alu_valid_i && m_ar && (alu_rd_i != 5'd0)) sb.push_back({alu_rd_i, alu_data_i});
    end
  endtask

  task automatic run(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic fl);
    drive(lv, lrd, ld, av, ard, ad, fl);
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // lv lrd ld  av ard ad  fl | lsu_ready alu_ready count
    tbl[0]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 1};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 0};
    tbl[3]  = '{1'b1, 5'd3,  32'h11, 1'b1, 5'd3,  32'h22, 1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 2};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 1};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd0,  32'h55, 1'b0, 1'b1, 1'b1, 0};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 0};
    tbl[9]  = '{1'b1, 5'd1,  32'hA1, 1'b1, 5'd2,  32'hA2, 1'b0, 1'b1, 1'b1, 0};
    tbl[10] = '{1'b1, 5'd3,  32'hA3, 1'b1, 5'd4,  32'hA4, 1'b0, 1'b1, 1'b1, 2};
    tbl[11] = '{1'b1, 5'd5,  32'hA5, 1'b1, 5'd6,  32'hA6, 1'b0, 1'b1, 1'b0, 3};
    tbl[12] = '{1'b1, 5'd7,  32'hA7, 1'b1, 5'd8,  32'hA8, 1'b0, 1'b1, 1'b0, 3};
    tbl[13] = '{1'b1, 5'd9,  32'hA9, 1'b1, 5'd10, 32'hAA, 1'b1, 1'b0, 1'b0, 3};
    tbl[14] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 0};
    tbl[15] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd11, 32'hB1, 1'b0, 1'b1, 1'b1, 0};
    tbl[16] = '{1'b1, 5'd0,  32'hC0, 1'b1, 5'd12, 32'hB2, 1'b0, 1'b1, 1'b1, 1};
    tbl[17] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 1};
    tbl[18] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b1, 1'b1, 0};

    rst_i = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #3;
    chk("rst_we",        {63'd0, we_o}, 64'd0);
    chk("rst_waddr",     64'(waddr_o), 64'd0);
    chk("rst_wdata",     64'(wdata_o), 64'd0);
    chk("rst_busy",      64'(busy_o), 64'd0);
    chk("rst_count",     64'(count_o), 64'd0);
    chk("rst_lsu_ready", {63'd0, lsu_ready_o}, 64'd1);
    chk("rst_alu_ready", {63'd0, alu_ready_o}, 64'd1);
    #10 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int v = 0; v < 19; v++) begin
      drive(tbl[v].lv, tbl[v].lrd, tbl[v].ld, tbl[v].av, tbl[v].ard, tbl[v].ad, tbl[v].fl);
      @(negedge clk_i);
      chk($sformatf("tbl%0d_lsu_ready", v), {63'd0, lsu_ready_o}, {63'd0, tbl[v].exp_lr});
      chk($sformatf("tbl%0d_alu_ready", v), {63'd0, alu_ready_o}, {63'd0, tbl[v].exp_ar});
      chk($sformatf("tbl%0d_count", v), 64'(count_o), 64'(tbl[v].exp_cnt));
      model_step();
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset between edges with two entries queued.
    run(1'b1, 5'd13, 32'hE1, 1'b1, 5'd14, 32'hE2, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("pre_rst_count", 64'(count_o), 64'd2);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_we",        {63'd0, we_o}, 64'd0);
    chk("arst_count",     64'(count_o), 64'd0);
    chk("arst_busy",      64'(busy_o), 64'd0);
    chk("arst_waddr",     64'(waddr_o), 64'd0);
    chk("arst_lsu_ready", {63'd0, lsu_ready_o}, 64'd1);
    chk("arst_alu_ready", {63'd0, alu_ready_o}, 64'd1);
    sb.delete();
    #1 rst_i = 1'b0;
    for (int c = 0; c < 3; c++) run(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

    // Traffic resumes normally after reset.
    run(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hF00D, 1'b0);
    run(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter NUMREGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter DATAWIDTH, default 32, result data width.
REQ-003 SHALL have parameter DEPTH, default 4, writeback queue entries (power of two, >= 2).
REQ-004 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port flush_i, input, 1, synchronous discard of all queued results.
REQ-007 SHALL have ports lsu_valid_i (input, 1), lsu_ready_o (output, 1), lsu_rd_i (input, $clog2(NUMREGS)) and lsu_data_i (input, DATAWIDTH), forming the load/store result producer.
REQ-008 SHALL have ports alu_valid_i (input, 1), alu_ready_o (output, 1), alu_rd_i (input, $clog2(NUMREGS)) and alu_data_i (input, DATAWIDTH), forming the ALU result producer.
REQ-009 SHALL have ports we_o (output, 1), waddr_o (output, $clog2(NUMREGS)) and wdata_o (output, DATAWIDTH), which drive the register bank write port.
REQ-010 SHALL have port busy_o, output, NUMREGS, per-register pending-write mask.
REQ-011 SHALL have port count_o, output, $clog2(DEPTH)+1, number of occupied queue entries.

Function
REQ-012 SHALL hold accepted results in a circular FIFO of DEPTH entries, each entry {rd, data}, with read/write pointers wrapping modulo DEPTH.
REQ-013 SHALL complete a handshake on a producer when valid and ready are both high at a rising edge.
REQ-014 SHALL drive lsu_ready_o = !flush_i && (count_o <= DEPTH-1), from registered count only, independent of any same-cycle pop.
REQ-015 SHALL drive alu_ready_o = !flush_i && (count_o <= DEPTH-2 when lsu_valid_i is high, else count_o <= DEPTH-1).
REQ-016 SHALL enqueue the LSU result before the ALU result when both handshake in the same cycle (LSU older in FIFO order).
REQ-017 SHALL complete the handshake for a result with rd == 0 but SHALL NOT enqueue it.
REQ-018 SHALL drive we_o = (count_o != 0) && !flush_i, with waddr_o/wdata_o equal to the head entry's rd/data (combinational from head).
REQ-019 SHALL pop the head at every rising edge where we_o is high; the consumer is always ready.
REQ-020 SHALL, for a result accepted at edge N into an empty queue, assert we_o in the cycle following edge N (one-cycle push-to-write latency), so the bank is written at edge N+1.
REQ-021 SHALL update count_o each edge as count + pushes(0..2) - pop(0..1); it never exceeds DEPTH nor underflows.
REQ-022 SHALL preserve strict FIFO order; two queued writes to the same rd retire oldest first.
REQ-023 SHALL set busy_o[r] while any queued entry targets r; busy_o[0] SHALL always be 0.
REQ-024 SHALL, on flush_i high at an edge, empty the queue (pointers and count to 0), drop the head without a write, and accept no input that cycle.
REQ-025 SHALL drive waddr_o and wdata_o to 0 when we_o is low.

Reset
REQ-026 SHALL, while rst_i is high, force pointers and count to 0 asynchronously, giving we_o=0, waddr_o=0, wdata_o=0, busy_o=0, count_o=0, lsu_ready_o=1 and alu_ready_o=1 (flush_i low).
REQ-027 SHALL discard queued entries and in-flight handshakes when reset asserts mid-operation; no write SHALL be issued after reset deasserts until a new result is accepted.
REQ-028 SHALL NOT require reset of entry storage contents.

Verification
REQ-029 SHALL cover single ALU result: alu rd=5, data=0xDEADBEEF accepted at edge N -> cycle after N: we_o=1, waddr_o=5, wdata_o=0xDEADBEEF, busy_o[5]=1; after edge N+1: we_o=0, busy_o=0.
REQ-030 SHALL cover simultaneous producers: LSU rd=3/0x11 and ALU rd=3/0x22 in the same cycle -> writes 0x11 then 0x22 on consecutive cycles, and busy_o[3] clears after the second write.
REQ-031 SHALL cover fill/backpressure with DEPTH=4: hold both producers valid with the queue at count 3 -> lsu_ready_o=1 and alu_ready_o=0; at count 4 both ready signals are 0; count_o never exceeds 4.
REQ-032 SHALL cover the x0 drop: alu rd=0, data=0x55 -> handshake completes, count_o stays 0, we_o stays 0.
REQ-033 SHALL cover flush: with 3 entries queued, pulse flush_i for one cycle -> we_o=0 that cycle, count_o=0 and busy_o=0 after the edge, and no input accepted that cycle.
REQ-034 SHALL cover asynchronous reset mid-operation: assert rst_i between edges with 2 entries queued -> we_o and count_o go to 0 immediately, with no write after release.
